// File: rtl/w21_col_mac_if.sv
// Bundle between the w21 column MAC engine, its weight ROM,
// the activation source and the next layer stage.
interface w21_col_mac_if #(
  parameter int ADDR_W = 9,
  parameter int W_W    = 21,
  parameter int X_W    = 16,
  parameter int ACC_W  = 48
);
  logic              start;
  logic [X_W-1:0]    x_in;
  logic              x_valid;
  logic              x_ready;
  logic [ADDR_W-1:0] adrs_clm;
  logic [W_W-1:0]    w_in;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              busy;

  modport master (
    output start, x_in, x_valid, w_in, acc_ready,
    input  x_ready, adrs_clm, acc_out, acc_valid, busy
  );

  modport slave (
    input  start, x_in, x_valid, w_in, acc_ready,
    output x_ready, adrs_clm, acc_out, acc_valid, busy
  );
endinterface

// File: rtl/w21_col_mac.sv
// Column dot-product engine: walks the w21 ROM column, MACs with x_in.
// Build option W21_COL_MAC_RELU_EN clamps negative results to zero.
module w21_col_mac #(
  parameter int DEPTH  = 300,
  parameter int ADDR_W = 9,
  parameter int W_W    = 21,
  parameter int X_W    = 16,
  parameter int ACC_W  = 48
) (
  input logic         clk,
  input logic         rst,
  w21_col_mac_if.slave bus
);
  localparam int PW = W_W + X_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        adrs_q;
  logic signed [PW-1:0]     prod_q;
  logic signed [PW-1:0]     prod_d;
  logic                     prod_v_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  res;
  logic                     x_ready_q;
  logic                     acc_valid_q;
  logic                     busy_q;
  logic                     hs;
  logic signed [PW-1:0]     w_ext;
  logic signed [PW-1:0]     x_ext;

  assign hs    = bus.x_valid & x_ready_q;
  assign w_ext = {{X_W{bus.w_in[W_W-1]}}, bus.w_in};
  assign x_ext = {{W_W{bus.x_in[X_W-1]}}, bus.x_in};
  assign prod_d = w_ext * x_ext;
  assign acc_d = acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      adrs_q      <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      acc_q       <= '0;
      x_ready_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (prod_v_q)
        acc_q <= acc_d;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q     <= '0;
            adrs_q    <= '0;
            prod_v_q  <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          prod_v_q <= hs;
          if (hs) begin
            prod_q <= prod_d;
            if (adrs_q == LAST) begin
              adrs_q    <= '0;
              x_ready_q <= 1'b0;
              state_q   <= DRAIN;
            end else begin
              adrs_q <= adrs_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // last product lands in acc this cycle
          prod_v_q    <= 1'b0;
          acc_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.acc_ready) begin
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef W21_COL_MAC_RELU_EN
  assign res = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign res = acc_q;
`endif

  assign bus.acc_out   = acc_valid_q ? res : '0;
  assign bus.acc_valid = acc_valid_q;
  assign bus.x_ready   = x_ready_q;
  assign bus.adrs_clm  = adrs_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_w21_col_mac.sv
// Directed bench for w21_col_mac with stub weight sources.
// Expected results switch with W21_COL_MAC_RELU_EN.
module tb_w21_col_mac;
  logic clk = 1'b0;
  logic rst;
  int   wmode;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  w21_col_mac_if bus ();

  w21_col_mac dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [20:0] rom_c3(input logic [8:0] a);
    logic [31:0] t;
    t = {23'd0, a} * 32'd40503 + 32'd777;
    return t[20:0] ^ 21'h15A5A5;
  endfunction

  always_comb begin
    bus.w_in = '0;
    if (wmode == 0)
      bus.w_in = 21'(bus.adrs_clm);
    else if (wmode == 1)
      bus.w_in = '1;
    else
      bus.w_in = rom_c3(bus.adrs_clm);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_dot(
    input  int          mode,
    input  logic [15:0] xv,
    input  bit          tog,
    input  int          hold,
    input  int          mid_start,
    output logic [47:0] res,
    output int          lat,
    output int          nhs,
    output int          aerr
  );
    int cyc;
    wmode = mode;
    bus.x_in = xv;
    nhs = 0;
    aerr = 0;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_valid = 1'b1;
    bus.acc_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.acc_valid && cyc < 2000) begin
      bus.start = (cyc == mid_start);
      if (tog)
        bus.x_valid = cyc[0];
      if (bus.x_ready) begin
        if (bus.adrs_clm !== 9'(nhs))
          aerr++;
        if (bus.x_valid)
          nhs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (bus.acc_valid)
      lat = cyc;
    res = bus.acc_out;
    for (int i = 0; i < hold; i++) begin
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== res ||
          bus.busy !== 1'b1)
        aerr++;
      @(negedge clk);
    end
    bus.acc_ready = 1'b1;
    @(negedge clk);
    bus.acc_ready = 1'b0;
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_valid", 64'(bus.acc_valid), 64'd0);
  endtask

  initial begin
    logic [47:0] res;
    logic [47:0] e;
    int          lat;
    int          nhs;
    int          aerr;
    longint      sum;
    logic [20:0] v;

    rst = 1'b1;
    wmode = 0;
    bus.start = 1'b0;
    bus.x_in = '0;
    bus.x_valid = 1'b0;
    bus.acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_adrs", 64'(bus.adrs_clm), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.acc_valid), 64'd0);
    chk("rst_xrdy", 64'(bus.x_ready), 64'd0);
    chk("rst_acc", 64'(bus.acc_out), 64'd0);
    rst = 1'b0;

    // ramp weights, x=1
    run_dot(0, 16'd1, 1'b0, 0, 0, res, lat, nhs, aerr);
    chk("t1_acc", 64'(res), 64'd44850);
    chk("t1_lat", 64'(lat), 64'd302);
    chk("t1_hs", 64'(nhs), 64'd300);
    chk("t1_adr", 64'(aerr), 64'd0);

    // w=-1, x=2, x_valid toggling
    run_dot(1, 16'd2, 1'b1, 0, 0, res, lat, nhs, aerr);
`ifdef W21_COL_MAC_RELU_EN
    e = 48'd0;
`else
    e = 48'(-64'sd600);
`endif
    chk("t2_acc", 64'(res), 64'(e));
    chk("t2_hs", 64'(nhs), 64'd300);
    chk("t2_hold", 64'(aerr), 64'd0);

    // downstream backpressure
    run_dot(0, 16'd1, 1'b0, 5, 0, res, lat, nhs, aerr);
    chk("t3_acc", 64'(res), 64'd44850);
    chk("t3_stable", 64'(aerr), 64'd0);

    // reset in mid-run
    wmode = 0;
    bus.x_in = 16'd1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 1000 && bus.adrs_clm != 9'd100; i++)
      @(negedge clk);
    chk("t4_at100", 64'(bus.adrs_clm), 64'd100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_adrs", 64'(bus.adrs_clm), 64'd0);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_valid", 64'(bus.acc_valid), 64'd0);
    chk("t4_xrdy", 64'(bus.x_ready), 64'd0);
    run_dot(0, 16'd1, 1'b0, 0, 0, res, lat, nhs, aerr);
    chk("t4_acc", 64'(res), 64'd44850);

    // ROM-like column with a stray start during RUN
    sum = 0;
    for (int a = 0; a < 300; a++) begin
      v = rom_c3(9'(a));
      sum += v[20] ? longint'(v) - 64'sd2097152 : longint'(v);
    end
`ifdef W21_COL_MAC_RELU_EN
    if (sum < 0)
      sum = 0;
`endif
    e = 48'(sum);
    run_dot(2, 16'd1, 1'b0, 0, 50, res, lat, nhs, aerr);
    chk("t5_acc", 64'(res), 64'(e));
    chk("t5_hs", 64'(nhs), 64'd300);
    chk("t5_lat", 64'(lat), 64'd302);

    // w=-1, x=1
    run_dot(1, 16'd1, 1'b0, 0, 0, res, lat, nhs, aerr);
`ifdef W21_COL_MAC_RELU_EN
    e = 48'd0;
`else
    e = 48'(-64'sd300);
`endif
    chk("t6_acc", 64'(res), 64'(e));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
